// File: rtl/rf_loader_if.sv
// -----------------------------------------------------------------------------
// rf_loader_if
// Valid/ready beat stream that carries one register-file row per beat into
// the loader.
//
// Signals:
//   s_valid  source -> sink  a beat is present on s_data
//   s_ready  sink -> source  the sink can accept a beat this cycle
//   s_data   source -> sink  LANES lanes of DATA_W bits; lane k is
//                            s_data[k*DATA_W +: DATA_W]
//
// Modports:
//   master  the beat source (drives s_valid/s_data)
//   slave   the loader (drives s_ready)
// -----------------------------------------------------------------------------
interface rf_loader_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8
);
    logic                      s_valid;
    logic                      s_ready;
    logic [LANES*DATA_W-1:0]   s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/rf_loader.sv
// -----------------------------------------------------------------------------
// rf_loader
// Write-side sequencer for the x/w register file feeding the multiplier array.
// Each accepted beat becomes one register-file row write, one cycle later, for
// DEPTH consecutive rows starting at row 0. Lanes 0..3 carry x data and lanes
// 4..7 carry w data; lanes pass straight through without reordering.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        one-cycle request to begin a load at row 0 (IDLE only)
//   abort        cancels an in-progress load; a pending write is dropped
//   stream       beat stream (slave side: s_valid, s_ready, s_data)
//   rf_enable    register-file enable (asserted together with write)
//   write        register-file write strobe
//   idx          target row of the current write
//   data_out     lane data to the register file, same packing as s_data
//   busy         a load is in progress
//   done         one-cycle pulse after the final row has been written
//   rows_loaded  rows written in the current or last load
// -----------------------------------------------------------------------------
module rf_loader #(
    parameter  int DATA_W = 8,
    parameter  int LANES  = 8,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    rf_loader_if.slave              stream,
    output logic                    rf_enable,
    output logic                    write,
    output logic [IDX_W-1:0]        idx,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W:0]          rows_loaded
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] row;
    logic             last_row;
    logic             do_write;
    logic             clear_load;
    logic             done_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. s_ready depends on the state alone so
    // the source never sees a combinational path back from s_valid. An abort
    // in the same cycle as a handshake consumes the beat but suppresses its
    // write. The final row's write is issued from the DRAIN cycle, and done
    // follows one cycle later unless an abort arrives during DRAIN.
    always_comb begin
        state_next     = state;
        stream.s_ready = 1'b0;
        do_write       = 1'b0;
        clear_load     = 1'b0;
        done_next      = 1'b0;
        last_row       = (row == IDX_W'(DEPTH - 1));

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = LOAD;
                    clear_load = 1'b1;
                end
            end
            LOAD: begin
                stream.s_ready = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (stream.s_valid) begin
                    do_write = 1'b1;
                    if (last_row) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = IDLE;
                done_next  = !abort;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write path: captures the accepted beat and its row so the register
    // file sees it exactly one cycle after the handshake. idx and data_out
    // hold between writes. The row counter stops at the last row and only
    // returns to zero when a new load starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= '0;
            write       <= 1'b0;
            idx         <= '0;
            data_out    <= '0;
            done        <= 1'b0;
            rows_loaded <= '0;
        end else begin
            write <= do_write;
            done  <= done_next;
            if (clear_load) begin
                row         <= '0;
                rows_loaded <= '0;
            end else if (do_write) begin
                idx         <= row;
                data_out    <= stream.s_data;
                rows_loaded <= {1'b0, row} + 1'b1;
                if (!last_row) begin
                    row <= row + 1'b1;
                end
            end
        end
    end

    assign rf_enable = write;
    assign busy      = (state != IDLE);

endmodule

// File: doc/rf_loader.md
Name: rf_loader

Overview:
- Write-side sequencer for the x/w register file that feeds the multiplier array.
- Accepts a valid/ready stream of 8-lane beats, one beat per row.
- Drives rf_enable/write/idx and the eight 8-bit lane data buses, so DEPTH consecutive rows get written starting at row 0.
- Signals completion with a one-cycle done pulse. Lanes 0-3 carry x data and lanes 4-7 carry w data, matching the register-file lane map.

Parameters:
- DATA_W, 8, width of one lane in bits.
- LANES, 8, lanes per beat; lanes 0..3 are x, lanes 4..7 are w.
- DEPTH, 8, rows per load; idx width is IDX_W = $clog2(DEPTH), which is 3 at the default.

Ports:
- clk  in  1  single clock; every state element is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load at row 0; ignored unless the FSM is in IDLE.
- abort  in  1  cancels an in-progress load; any pending registered write is dropped.
- s_valid  in  1  a beat is present on s_data.
- s_ready  out  1  the loader can accept a beat.
- s_data  in  LANES*DATA_W  beat payload; lane k is s_data[k*DATA_W +: DATA_W].
- rf_enable  out  1  register-file enable.
- write  out  1  register-file write strobe.
- idx  out  IDX_W  target row.
- data_out  out  LANES*DATA_W  lane data to the register file, same packing as s_data.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse once the final row has been written.
- rows_loaded  out  IDX_W+1  count of rows written in the current or last load.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE.
  - rf_enable=0, write=0, idx=0, data_out=0, s_ready=0, busy=0, done=0, rows_loaded=0.
  - rst has priority over start and abort, and over any in-flight beat.
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE: s_ready=0. On start, go to LOAD, clear the row counter and rows_loaded, and set busy=1 from the next cycle.
  - LOAD: s_ready=1, driven combinationally from the state only and never from s_valid. A handshake (s_valid&&s_ready) at cycle N for row r produces the following at cycle N+1:
    - write=1, rf_enable=1, idx=r, data_out = the captured beat;
    - rows_loaded = r+1.
  - Without a handshake in a LOAD cycle, the next cycle has write=0 and rf_enable=0; data_out and idx hold their values.
  - If the handshake is for row DEPTH-1, go to DRAIN. In that cycle (N+1) s_ready=0 and the last write is issued.
  - DRAIN: lasts one cycle. done=1 in the cycle after it (N+2); busy falls in that same cycle; state returns to IDLE.
- Write path latency:
  - exactly one cycle from handshake to write;
  - back-to-back beats produce back-to-back writes with no bubble;
  - the row counter wraps to 0 only through start, never on its own.
- start:
  - ignored in LOAD and in DRAIN;
  - start in the same cycle as the done pulse is accepted (the FSM is in IDLE then), so a new load begins.
- abort:
  - in LOAD: go to IDLE next cycle; write=0 next cycle, even if a handshake happened in the abort cycle (that beat is consumed but discarded); done is not pulsed; busy=0; rows_loaded holds its value.
  - in DRAIN: the last write still completes because it is already on the bus; done is suppressed.
  - in IDLE: no effect.
  - abort together with start in IDLE: abort wins and the FSM stays in IDLE.
- s_valid while s_ready=0: not consumed; the source must hold it.
- Lane order preserved: s_data lane k always appears on data_out lane k; no byte swapping.

Test Plan:
- Reset then idle: rst high 2 cycles, s_valid=1 with no start -> s_ready=0, write=0, idx=0, data_out=0, busy=0 throughout.
- Full back-to-back load: start, then 8 beats with lane k of row r = 16*r+k, s_valid held high -> writes on 8 consecutive cycles with idx 0..7, data_out lane k = 16*idx+k; done pulses exactly once, 2 cycles after the 8th handshake; rows_loaded=8.
- Throttled source: s_valid toggling 1,0,0,1,... -> writes only the cycle after each handshake, idx strictly sequential, no duplicated or skipped row, done still after row 7.
- Abort mid-load: abort in the cycle of the 4th handshake -> exactly 3 writes (idx 0..2), no write for the 4th beat, no done, busy=0 next cycle, rows_loaded=3.
- start ignored while busy: start pulsed during row 5 -> the load continues to row 7 without restarting; a start in the done cycle begins a new load at idx 0.
- Synchronous reset mid-load: rst asserted after row 2 -> the following cycle has write=0, idx=0, s_ready=0, busy=0, done=0; a subsequent start reloads cleanly from row 0.
